s1_fetch: RTL

Pipeline stage-1 fetch unit. It generates the fetch PC, drives the synchronous-read BIOS and IMEM instruction ports, and delivers `instruction_s2` and `pc_s2` to the stage-2 control decoder. It also accepts stall and branch/jump redirects coming back from stage 2. It covers boot sequencing, stall-hold buffering and unmapped-region faulting, so stage 2 always sees a stable, legal instruction word.

---
 rtl/s1_fetch.sv | 122 ++++++++++++
 1 files changed

// File: rtl/s1_fetch.sv
// Stage-1 fetch: generates the fetch PC, drives the BIOS/IMEM sync-read ports
// and presents a stable instruction/PC pair to stage 2.
module s1_fetch #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [11:0] bios_addr,
  input  logic [31:0] bios_dout,
  output logic [13:0] imem_addr,
  input  logic [31:0] imem_dout,
  output logic [31:0] pc_s2,
  output logic [31:0] instruction_s2,
  output logic        valid_s2,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_e;

  localparam logic [3:0] REG_BIOS = 4'h4;
  localparam logic [3:0] REG_IMEM = 4'h1;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_q, hold_d;
  logic        hold_vld_q, hold_vld_d;
  logic [3:0]  region_q;

  logic [31:0] fetch_pc;
  logic [31:0] seq_pc;
  logic [31:0] tgt_pc;
  logic [31:0] mem_insn;
  logic        mapped;
  logic        unused_bits;

  assign seq_pc = pc_q + 32'd4;
  assign tgt_pc = {redirect_pc[31:2], 2'b00};

  // region_q tracks the PC whose data is on the memory dout this cycle
  assign mapped = (region_q == REG_BIOS) || (region_q == REG_IMEM);

  always_comb begin
    mem_insn = NOP_INSN;
    case (region_q)
      REG_BIOS: mem_insn = bios_dout;
      REG_IMEM: mem_insn = imem_dout;
      default:  mem_insn = NOP_INSN;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    hold_d         = hold_q;
    hold_vld_d     = hold_vld_q;
    fetch_pc       = seq_pc;
    instruction_s2 = NOP_INSN;
    valid_s2       = 1'b0;
    fetch_fault    = 1'b0;
    case (state_q)
      BOOT: begin
        fetch_pc = RESET_PC;
        pc_d     = RESET_PC;
        state_d  = RUN;
      end
      RUN: begin
        // every RUN cycle shows a PC for the first time, so a fault pulses here only
        instruction_s2 = mem_insn;
        valid_s2       = mapped;
        fetch_fault    = ~mapped;
        if (stall) begin
          hold_d     = mem_insn;
          hold_vld_d = mapped;
          state_d    = HOLD;
        end else begin
          if (redirect) fetch_pc = tgt_pc;
          pc_d = fetch_pc;
        end
      end
      HOLD: begin
        instruction_s2 = hold_q;
        valid_s2       = hold_vld_q;
        if (!stall) begin
          if (redirect) fetch_pc = tgt_pc;
          pc_d    = fetch_pc;
          state_d = RUN;
        end
      end
      default: begin
        fetch_pc = RESET_PC;
        state_d  = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      hold_q     <= NOP_INSN;
      hold_vld_q <= 1'b0;
      region_q   <= RESET_PC[31:28];
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      region_q   <= fetch_pc[31:28];
    end
  end

  assign bios_addr = fetch_pc[13:2];
  assign imem_addr = fetch_pc[15:2];
  assign pc_s2     = pc_q;

  assign unused_bits = ^{fetch_pc[27:16], fetch_pc[1:0], redirect_pc[1:0]};

endmodule
